dmem_sram_bridge: RTL and testbench
===================================

# dmem_sram_bridge

Memory-stage bridge between the byte-lane data-access logic and the SRAM-like data bus. It turns a memory-stage load or store (word-aligned address, byte write enables, lane-replicated write data) into one `req`/`addr_ok`/`data_ok` transaction. While the transaction is outstanding it stalls the pipeline. It returns the raw 32-bit read word to the load-extraction logic. When the pipeline is flushed it cancels the pending access without breaking the bus protocol.

## Interface
- No parameters.
- `clk`  in  1  core clock.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_en`  in  1  M-stage instruction is a load or store.
- `mem_wen`  in  4  byte write enables; `0000` means load.
- `mem_addr`  in  32  virtual access address.
- `mem_wdata`  in  32  write data, already replicated into lanes.
- `mem_exc`  in  1  M-stage address error or other exception; the access is suppressed.
- `flush`  in  1  pipeline flush, M stage discarded.
- `stall_other`  in  1  pipeline held by another source.
- `stall_dmem`  out  1  request pipeline hold.
- `mem_rdata`  out  32  raw read word.
- `data_req`  out  1
- `data_wr`  out  1
- `data_size`  out  2
- `data_addr`  out  32
- `data_wdata`  out  32
- `data_wstrb`  out  4
- `data_addr_ok`  in  1
- `data_data_ok`  in  1
- `data_rdata`  in  32

## Operation
- `start = mem_en & ~mem_exc & ~flush`.
- States: IDLE, ADDR (request presented, waiting for `addr_ok`), DATA (waiting for `data_ok`), DONE (access finished, pipeline still held). A register `cancel` marks a discarded transaction.
- Request presentation:
  - `data_req = (IDLE & start) | ADDR`. The request is issued combinationally from IDLE.
  - Bus fields are driven from the inputs and must be stable while `req` is high, because the M-stage register holds its value during a stall.
  - Once `req` is asserted it stays high until `addr_ok`. A flush never withdraws it.
- Bus field encoding:
  - `data_wr = |mem_wen`.
  - `data_wstrb = mem_wen`.
  - `data_wdata = mem_wdata`.
  - Store size: `1111` gives 2; `0011` or `1100` gives 1; one-hot gives 0.
  - Load size: always 2, with `data_addr[1:0] = 00`. Byte and halfword selection happens downstream.
  - Store address: `data_addr[1:0] = mem_addr[1:0]`.
- Transitions:
  - IDLE→ADDR: `start & ~addr_ok`.
  - IDLE→DATA: `start & addr_ok`.
  - ADDR→DATA: on `addr_ok`.
  - DATA→DONE: `data_ok & stall_other & ~cancel`.
  - DATA→IDLE: `data_ok` when `~stall_other` or `cancel` is set.
  - DONE→IDLE: when `~stall_other`.
  - DONE never reissues a request for the same instruction.
- Read data capture:
  - On `data_ok & ~cancel & ~data_wr_q`, `data_rdata` is latched into `rdata_q`.
  - `mem_rdata = (DATA & data_ok) ? data_rdata : rdata_q`.
- Cancel:
  - `cancel` is set by `flush` in ADDR or DATA.
  - It is cleared when the state returns to IDLE.
  - While `cancel` is set, `data_ok` neither updates `rdata_q` nor enters DONE.
- Stall:
  - `stall_dmem = (IDLE & start) | ((ADDR | DATA) & ~cancel & ~(DATA & data_ok)) | ((ADDR | DATA) & cancel & mem_en & ~flush)`.
  - The last term holds a new post-flush instruction until the cancelled transaction drains.
- At most one transaction is outstanding.

## Timing
- Reset values:
  - state IDLE, `cancel = 0`, `rdata_q = 0`.
  - `data_req = 0`, `stall_dmem = 0`, `mem_rdata = 0`.
  - Bus fields follow the inputs combinationally.
- Best-case load: `addr_ok` in the same cycle as `req`, and `data_ok` one cycle later. `stall_dmem` is high for 1 cycle, and the data is valid at M in the cycle after the request.
- Minimum stall: `stall_dmem` falls in the cycle where `data_ok` is seen.
- `mem_rdata` is stable through DONE until the next captured load.
- Reset asserted mid-transaction: the block returns to IDLE immediately and the bus slave is reset by the same `rst`.
- `flush` in the same cycle as `data_ok` in DATA: the data is discarded and the next state is IDLE.
- `flush` in the same cycle as IDLE `start`: no request is issued.

## Configuration
- `DMEM_ADDR_MAP_EN` defined: `data_addr` maps the fixed segments:
  - 0x8000_0000–0xBFFF_FFFF becomes `{3'b000, mem_addr[28:0]}`.
  - All other addresses pass through unchanged.
- `DMEM_ADDR_MAP_EN` undefined: `data_addr = mem_addr` with the load alignment rule above.

## Test plan
- Load from 0x8000_0004 with `addr_ok` immediate and `data_ok` next cycle, `rdata` 0xDEADBEEF:
  - With `DMEM_ADDR_MAP_EN`, `data_addr` = 0x0000_0004.
  - `stall_dmem` is high for 1 cycle.
  - `mem_rdata` = 0xDEADBEEF.
- Store with `mem_wen` = 1100 at 0x1002, wdata 0x12341234, `addr_ok` delayed 3 cycles: `req` is held for 4 cycles with size = 1, wstrb = 1100, and wr = 1. No `rdata_q` update.
- Load completes while `stall_other` = 1 for 2 more cycles:
  - The state passes through DONE.
  - No second `req` is issued.
  - `mem_rdata` holds its value.
  - The state returns to IDLE when `stall_other` falls.
- `flush` during DATA, then a new load at M:
  - `stall_dmem` stays high until the old `data_ok`.
  - The old data is discarded.
  - The new `req` is issued in the next cycle.
- `mem_exc` = 1 with `mem_en` = 1: `data_req` and `stall_dmem` both stay 0.
- `rst` asserted in ADDR: `data_req` drops asynchronously and the state is IDLE.

Source files
------------

// File: rtl/dmem_sram_bridge.sv
// Memory-stage bridge from the byte-lane load/store unit to the req/addr_ok/data_ok data bus.
// Optional macro DMEM_ADDR_MAP_EN folds 0x8000_0000-0xBFFF_FFFF onto physical {3'b000, addr[28:0]}.
`timescale 1ns/1ps
module dmem_sram_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic [3:0]  mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_exc,
  input  logic        flush,
  input  logic        stall_other,
  output logic        stall_dmem,
  output logic [31:0] mem_rdata,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_wstrb,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_e;

  state_e      state_q, state_d;
  logic        cancel_q, cancel_d;
  logic        wr_q, wr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        start;
  logic [31:0] phys_addr;

  function automatic logic [1:0] size_enc(input logic [3:0] wen);
    case (wen)
      4'b1111:                            size_enc = 2'd2;
      4'b0011, 4'b1100:                   size_enc = 2'd1;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size_enc = 2'd0;
      default:                            size_enc = 2'd2;
    endcase
  endfunction

  function automatic logic [31:0] map_addr(input logic [31:0] a);
`ifdef DMEM_ADDR_MAP_EN
    map_addr = (a[31:30] == 2'b10) ? {3'b000, a[28:0]} : a;
`else
    map_addr = a;
`endif
  endfunction

  // Bus fields come straight from the held M-stage register, so they stay stable while req is up.
  assign start      = mem_en & ~mem_exc & ~flush;
  assign phys_addr  = map_addr(mem_addr);
  assign data_wr    = |mem_wen;
  assign data_wstrb = mem_wen;
  assign data_wdata = mem_wdata;
  assign data_size  = size_enc(mem_wen);
  assign data_addr  = data_wr ? phys_addr : {phys_addr[31:2], 2'b00};
  assign mem_rdata  = (state_q == S_DATA && data_data_ok) ? data_rdata : rdata_q;

  always_comb begin
    state_d    = state_q;
    cancel_d   = cancel_q;
    wr_d       = wr_q;
    rdata_d    = rdata_q;
    data_req   = 1'b0;
    stall_dmem = 1'b0;
    case (state_q)
      S_IDLE: begin
        data_req   = start;
        stall_dmem = start;
        cancel_d   = 1'b0;
        if (start) begin
          wr_d    = |mem_wen;
          state_d = data_addr_ok ? S_DATA : S_ADDR;
        end
      end
      S_ADDR: begin
        // A flush never withdraws req; the access is only marked for discard.
        data_req   = 1'b1;
        cancel_d   = cancel_q | flush;
        stall_dmem = ~cancel_q | (mem_en & ~flush);
        if (data_addr_ok) state_d = S_DATA;
      end
      S_DATA: begin
        cancel_d   = cancel_q | flush;
        stall_dmem = cancel_q ? (mem_en & ~flush) : ~data_data_ok;
        if (data_data_ok) begin
          if (~cancel_q & ~flush & ~wr_q) rdata_d = data_rdata;
          if (stall_other & ~cancel_q & ~flush) begin
            state_d = S_DONE;
          end else begin
            state_d  = S_IDLE;
            cancel_d = 1'b0;
          end
        end
      end
      S_DONE: begin
        if (~stall_other) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cancel_q <= 1'b0;
      wr_q     <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      cancel_q <= cancel_d;
      wr_q     <= wr_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_sram_bridge.sv
// Bench for dmem_sram_bridge: directed bus scenarios, then random loads/stores against a
// word-array memory model with a randomly slow bus slave.
`timescale 1ns/1ps
module tb_dmem_sram_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_en, mem_exc, flush, stall_other;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic        stall_dmem, data_req, data_wr;
  logic [31:0] mem_rdata, data_addr, data_wdata, data_rdata;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;

  dmem_sram_bridge dut (
    .clk(clk), .rst(rst), .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_exc(mem_exc), .flush(flush), .stall_other(stall_other),
    .stall_dmem(stall_dmem), .mem_rdata(mem_rdata), .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_wstrb(data_wstrb), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference view of the bus address: segment fold (when enabled), loads word-aligned.
  function automatic logic [31:0] exp_bus_addr(input logic [31:0] a, input logic [3:0] wen);
    logic [31:0] m;
    m = a;
`ifdef DMEM_ADDR_MAP_EN
    if (a >= 32'h8000_0000 && a <= 32'hBFFF_FFFF) m = a & 32'h1FFF_FFFF;
`endif
    if (wen == 4'b0000) m = m & 32'hFFFF_FFFC;
    return m;
  endfunction

  function automatic logic [1:0] exp_size(input logic [3:0] wen);
    case ($countones(wen))
      4:       return 2'd2;
      2:       return 2'd1;
      1:       return 2'd0;
      default: return 2'd2;
    endcase
  endfunction

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  // Random-phase state: current M-stage instruction, bus slave, memory images.
  logic [31:0] ref_mem [64];
  logic [31:0] bus_mem [64];
  logic        cur_en, cur_exc;
  logic [3:0]  cur_wen;
  logic [31:0] cur_addr, cur_wdata;
  int          hs_cnt, wait_cyc, addr_wait, data_wait;
  logic        got_data, pend, pend_wr;
  logic [5:0]  pend_idx;
  logic [3:0]  pend_wstrb;
  logic [31:0] pend_wdata;

  task automatic new_instr();
    int k, seg, sel;
    logic [31:0] hi, v;
    logic [1:0]  low;
    k   = int'($urandom_range(0, 9));
    seg = int'($urandom_range(0, 3));
    cur_en  = (k != 0);
    cur_exc = (k == 1);
    case (seg)
      0:       hi = 32'h0000_2000;
      1:       hi = 32'h8000_0000;
      2:       hi = 32'hA000_0000;
      default: hi = 32'hC000_0000;
    endcase
    v = $urandom;
    if ($urandom_range(0, 1) == 0) begin
      cur_wen   = 4'b0000;
      low       = 2'($urandom_range(0, 3));
      cur_wdata = v;
    end else begin
      sel = int'($urandom_range(0, 2));
      if (sel == 0) begin
        cur_wen = 4'b1111; low = 2'b00; cur_wdata = v;
      end else if (sel == 1) begin
        low = {1'($urandom_range(0, 1)), 1'b0};
        cur_wen = low[1] ? 4'b1100 : 4'b0011;
        cur_wdata = {2{v[15:0]}};
      end else begin
        low = 2'($urandom_range(0, 3));
        cur_wen = 4'b0001 << low;
        cur_wdata = {4{v[7:0]}};
      end
    end
    cur_addr = hi | (32'($urandom_range(0, 63)) << 2) | {30'b0, low};
    hs_cnt   = 0;
    got_data = 1'b0;
    wait_cyc = 0;
  endtask

  task automatic drive_random();
    mem_en       = cur_en;
    mem_exc      = cur_exc;
    mem_wen      = cur_wen;
    mem_addr     = cur_addr;
    mem_wdata    = cur_wdata;
    flush        = 1'b0;
    stall_other  = ($urandom_range(0, 3) == 0);
    data_addr_ok = (addr_wait == 0);
    data_data_ok = pend && (data_wait == 0);
    data_rdata   = data_data_ok ? bus_mem[pend_idx] : $urandom;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        req, aok, dok, hs, adv, active, is_load, prev_wait, abort;
    logic [5:0]  s_idx;
    logic        s_wr;
    logic [3:0]  s_wstrb;
    logic [31:0] s_wdata;
    int          retired;

    mem_en = 0; mem_exc = 0; flush = 0; stall_other = 0; mem_wen = 0;
    mem_addr = 0; mem_wdata = 0; data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
    #2 rst = 1'b1;

    // Reset values
    to_neg();
    check_eq("rst_req", 32'(data_req), 32'd0);
    check_eq("rst_stall", 32'(stall_dmem), 32'd0);
    check_eq("rst_rdata", mem_rdata, 32'h0);
    to_pos(); rst = 1'b0;

    // Best-case load from 0x8000_0004
    mem_en = 1; mem_wen = 4'b0000; mem_addr = 32'h8000_0004; data_addr_ok = 1;
    to_neg();
    check_eq("t1_req", 32'(data_req), 32'd1);
    check_eq("t1_stall", 32'(stall_dmem), 32'd1);
    check_eq("t1_addr", data_addr, exp_bus_addr(32'h8000_0004, 4'b0000));
    check_eq("t1_size", 32'(data_size), 32'd2);
    check_eq("t1_wr", 32'(data_wr), 32'd0);
    to_pos(); data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'hDEAD_BEEF;
    to_neg();
    check_eq("t1_stall_fall", 32'(stall_dmem), 32'd0);
    check_eq("t1_req_low", 32'(data_req), 32'd0);
    check_eq("t1_rdata", mem_rdata, 32'hDEAD_BEEF);
    to_pos(); mem_en = 0; data_data_ok = 0; data_rdata = 0;
    to_neg();
    check_eq("t1_rdata_hold", mem_rdata, 32'hDEAD_BEEF);
    check_eq("t1_idle_stall", 32'(stall_dmem), 32'd0);

    // Halfword store with addr_ok delayed three cycles
    to_pos(); mem_en = 1; mem_wen = 4'b1100; mem_addr = 32'h0000_1002; mem_wdata = 32'h1234_1234;
    for (int i = 0; i < 4; i++) begin
      to_neg();
      check_eq("t2_req", 32'(data_req), 32'd1);
      check_eq("t2_size", 32'(data_size), 32'd1);
      check_eq("t2_wstrb", 32'(data_wstrb), 32'hC);
      check_eq("t2_wr", 32'(data_wr), 32'd1);
      check_eq("t2_addr", data_addr, 32'h0000_1002);
      to_pos();
      data_addr_ok = (i == 2);
    end
    to_neg();
    check_eq("t2_req_drop", 32'(data_req), 32'd0);
    check_eq("t2_stall", 32'(stall_dmem), 32'd1);
    to_pos(); data_data_ok = 1; data_rdata = 32'hBAD0_BAD0;
    to_neg();
    check_eq("t2_stall_fall", 32'(stall_dmem), 32'd0);
    to_pos(); mem_en = 0; data_data_ok = 0; data_rdata = 0;
    to_neg();
    check_eq("t2_no_capture", mem_rdata, 32'hDEAD_BEEF);

    // Load finishing while another stall source holds the pipe
    to_pos(); mem_en = 1; mem_wen = 4'b0000; mem_addr = 32'h20; data_addr_ok = 1; stall_other = 1;
    to_neg();
    check_eq("t3_req", 32'(data_req), 32'd1);
    to_pos(); data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'hCAFE_F00D;
    to_neg();
    check_eq("t3_rdata", mem_rdata, 32'hCAFE_F00D);
    check_eq("t3_stall_fall", 32'(stall_dmem), 32'd0);
    for (int i = 0; i < 3; i++) begin
      to_pos(); data_data_ok = 0; data_rdata = 32'h5555_AAAA;
      stall_other = (i < 2);
      to_neg();
      check_eq("t3_no_second_req", 32'(data_req), 32'd0);
      check_eq("t3_hold", mem_rdata, 32'hCAFE_F00D);
      check_eq("t3_stall", 32'(stall_dmem), 32'd0);
    end
    to_pos(); mem_addr = 32'h24; data_rdata = 0;
    to_neg();
    check_eq("t3_back_idle", 32'(data_req), 32'd1);
    to_pos(); data_addr_ok = 1;
    to_neg();
    to_pos(); data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h1122_3344;
    to_neg();
    check_eq("t3b_rdata", mem_rdata, 32'h1122_3344);
    to_pos(); mem_en = 0; data_data_ok = 0; data_rdata = 0;

    // Flush while waiting for data, younger load arrives at M
    mem_en = 1; mem_wen = 4'b0000; mem_addr = 32'h40; data_addr_ok = 1;
    to_neg();
    check_eq("t4_req", 32'(data_req), 32'd1);
    to_pos(); data_addr_ok = 0; flush = 1;
    to_neg();
    check_eq("t4_flush_stall", 32'(stall_dmem), 32'd1);
    to_pos(); flush = 0; mem_addr = 32'h44;
    to_neg();
    check_eq("t4_no_req", 32'(data_req), 32'd0);
    check_eq("t4_hold_new", 32'(stall_dmem), 32'd1);
    to_pos(); data_data_ok = 1; data_rdata = 32'h0BAD_F00D;
    to_neg();
    check_eq("t4_drain_stall", 32'(stall_dmem), 32'd1);
    check_eq("t4_drain_req", 32'(data_req), 32'd0);
    to_pos(); data_data_ok = 0; data_rdata = 0;
    to_neg();
    check_eq("t4_new_req", 32'(data_req), 32'd1);
    check_eq("t4_new_addr", data_addr, 32'h44);
    check_eq("t4_discard", mem_rdata, 32'h1122_3344);
    to_pos(); data_addr_ok = 1;
    to_neg();
    to_pos(); data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h600D_D00D;
    to_neg();
    check_eq("t4_rdata", mem_rdata, 32'h600D_D00D);
    to_pos(); mem_en = 0; data_data_ok = 0; data_rdata = 0;
    to_neg();
    check_eq("t4_rdata_hold", mem_rdata, 32'h600D_D00D);

    // Exception and same-cycle flush suppress the access
    to_pos(); mem_en = 1; mem_exc = 1; mem_wen = 4'b1111; mem_addr = 32'h80; data_addr_ok = 1;
    to_neg();
    check_eq("t5_exc_req", 32'(data_req), 32'd0);
    check_eq("t5_exc_stall", 32'(stall_dmem), 32'd0);
    to_pos(); mem_exc = 0; flush = 1;
    to_neg();
    check_eq("t5_flush_req", 32'(data_req), 32'd0);
    check_eq("t5_flush_stall", 32'(stall_dmem), 32'd0);
    to_pos(); mem_en = 0; flush = 0; data_addr_ok = 0;
    to_neg();
    check_eq("t5_idle_req", 32'(data_req), 32'd0);

    // Asynchronous reset while a request waits for addr_ok
    to_pos(); mem_en = 1; mem_wen = 4'b0000; mem_addr = 32'h100;
    to_neg();
    check_eq("t6_req", 32'(data_req), 32'd1);
    to_pos();
    to_neg();
    #1 mem_en = 0;
    #1 check_eq("t6_addr_hold", 32'(data_req), 32'd1);
    rst = 1;
    #1 check_eq("t6_async_req", 32'(data_req), 32'd0);
    check_eq("t6_async_stall", 32'(stall_dmem), 32'd0);
    check_eq("t6_async_rdata", mem_rdata, 32'h0);
    to_pos(); rst = 0;
    to_neg();
    check_eq("t6_after_req", 32'(data_req), 32'd0);

    // Random traffic against the memory model
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = $urandom;
      bus_mem[i] = ref_mem[i];
    end
    pend = 0; pend_wr = 0; pend_idx = 0; pend_wstrb = 0; pend_wdata = 0;
    data_wait = 0; addr_wait = int'($urandom_range(0, 3));
    prev_wait = 0; abort = 0; retired = 0;
    new_instr();
    to_pos();
    drive_random();
    while (retired < 250 && !abort) begin
      @(negedge clk);
      req     = data_req;
      aok     = data_addr_ok;
      dok     = data_data_ok;
      hs      = req & aok;
      active  = cur_en & ~cur_exc;
      is_load = active && (cur_wen == 4'b0000);
      s_idx   = data_addr[7:2];
      s_wr    = data_wr;
      s_wstrb = data_wstrb;
      s_wdata = data_wdata;
      if (req) begin
        check_eq("r_addr", data_addr, exp_bus_addr(cur_addr, cur_wen));
        check_eq("r_size", 32'(data_size), 32'(exp_size(cur_wen)));
        check_eq("r_wr", 32'(data_wr), 32'(cur_wen != 4'b0000));
        check_eq("r_wstrb", 32'(data_wstrb), 32'(cur_wen));
        check_eq("r_wdata", data_wdata, cur_wdata);
        if (hs_cnt != 0) check_eq("r_dup_req", 32'(req), 32'd0);
        if (pend) check_eq("r_one_outstanding", 32'(req), 32'd0);
      end
      if (prev_wait) check_eq("r_req_hold", 32'(req), 32'd1);
      prev_wait = req & ~aok;
      if (!active) begin
        check_eq("r_idle_req", 32'(req), 32'd0);
        check_eq("r_idle_stall", 32'(stall_dmem), 32'd0);
      end
      if (dok) begin
        check_eq("r_stall_fall", 32'(stall_dmem), 32'd0);
        if (is_load) check_eq("r_rd_pass", mem_rdata, ref_mem[cur_addr[7:2]]);
      end else if (got_data && is_load) begin
        check_eq("r_rd_hold", mem_rdata, ref_mem[cur_addr[7:2]]);
      end
      adv = !stall_dmem && !stall_other;
      if (adv && active) begin
        check_eq("r_one_req", 32'(hs_cnt + int'(hs)), 32'd1);
        check_eq("r_completed", 32'(got_data | dok), 32'd1);
      end
      wait_cyc++;
      if (wait_cyc > 60) begin
        check_eq("r_timeout", 32'(wait_cyc), 32'd0);
        abort = 1;
      end

      @(posedge clk);
      if (dok) begin
        if (pend_wr)
          for (int b = 0; b < 4; b++)
            if (pend_wstrb[b]) bus_mem[pend_idx][8*b +: 8] = pend_wdata[8*b +: 8];
        pend = 0;
        got_data = 1;
      end else if (pend && data_wait > 0) begin
        data_wait--;
      end
      if (hs) begin
        pend = 1; pend_idx = s_idx; pend_wr = s_wr; pend_wstrb = s_wstrb; pend_wdata = s_wdata;
        data_wait = int'($urandom_range(0, 2));
        addr_wait = int'($urandom_range(0, 3));
        hs_cnt++;
      end else if (req && addr_wait > 0) begin
        addr_wait--;
      end
      if (adv) begin
        if (active && cur_wen != 4'b0000)
          for (int b = 0; b < 4; b++)
            if (cur_wen[b]) ref_mem[cur_addr[7:2]][8*b +: 8] = cur_wdata[8*b +: 8];
        retired++;
        new_instr();
      end
      #1;
      drive_random();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
